// File: rtl/hex_scan_display.sv
// -----------------------------------------------------------------------------
// hex_scan_display
//
// Time-multiplexed driver for an 8-digit, active-low, seven-segment display.
// A prescaler produces a one-cycle tick every DIV clocks. Each tick advances
// the scanned digit index and loads the segment pattern for that digit. The
// value shown is taken from a shadow copy of the input. The shadow is only
// refreshed at the frame boundary (the tick where the index wraps 7 -> 0), so a
// frame never mixes digits from two different input values.
//
// Parameters
//   DIV  : clk cycles per digit (2 .. 2^20)
//   LZB  : 1 = blank leading zero digits (digit 0 is never blanked)
//
// Ports
//   clk   : system clock; all state changes on its rising edge
//   Rst   : asynchronous active-high reset
//   data  : [32:1] value to show, [0] valid flag (0 -> all digits show a dash)
//   which : registered index of the digit currently driven (0 = data[4:1])
//   seg   : registered active-low segments {dp,g,f,e,d,c,b,a}; dp always off
// -----------------------------------------------------------------------------
module hex_scan_display #(
    parameter int DIV = 100000,
    parameter bit LZB = 1'b0
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [32:0] data,
    output logic [2:0]  which,
    output logic [7:0]  seg
);

    // Smallest counter width that can hold DIV-1.
    localparam int            CW         = $clog2(DIV);
    localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);

    logic [CW-1:0] presc_reg;
    logic          tick;
    logic [32:0]   shadow_reg;
    logic [32:0]   shadow_next;
    logic [2:0]    which_next;
    logic [7:0]    seg_next;

    logic [3:0]    nibble [8];
    logic [7:0]    nib_nz;
    logic [7:0]    upper_nz;
    logic [3:0]    cur_nibble;
    logic          digit_blank;

    assign tick       = (presc_reg == PRESC_LAST);
    assign which_next = which + 3'd1;

    // The decode on the frame-boundary tick must see the value captured on
    // that same edge, so the decode works from the shadow's next-state value.
    assign shadow_next = (tick && (which == 3'd7)) ? data : shadow_reg;

    // Split the value into nibbles and flag non-zero digits.
    // upper_nz[i] is set when any digit from i up to 7 is non-zero; a digit
    // with upper_nz clear lies entirely above the most significant non-zero
    // digit and is a leading zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
            assign nibble[gi]   = shadow_next[4*gi+1 +: 4];
            assign nib_nz[gi]   = |nibble[gi];
            assign upper_nz[gi] = |nib_nz[7:gi];
        end
    endgenerate

    assign cur_nibble  = nibble[which_next];
    assign digit_blank = LZB && (which_next != 3'd0) && !upper_nz[which_next];

    // Active-low hex font, dp (bit 7) held off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // An invalid value overrides both blanking and the hex font.
    always_comb begin
        seg_next = 8'hFF;
        if (!shadow_next[0]) begin
            seg_next = 8'hBF;
        end else if (digit_blank) begin
            seg_next = 8'hFF;
        end else begin
            seg_next = hex_to_seg(cur_nibble);
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            presc_reg  <= '0;
            which      <= 3'd0;
            shadow_reg <= 33'd0;
            seg        <= 8'hFF;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                which      <= which_next;
                shadow_reg <= shadow_next;
                seg        <= seg_next;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_display
//
// Two instances share clock, reset and data: one without and one with
// leading-zero blanking. Every time the scanned index changes, the next
// expected {which, seg, seg_lzb} entry is popped from a queue and compared,
// and the spacing since the previous tick (or reset release) is checked
// against DIV. Tests push the expected digits of each frame when they drive
// the data that frame will capture.
// -----------------------------------------------------------------------------
module tb_hex_scan_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        Rst;
    logic [32:0] data;
    logic [2:0]  which;
    logic [7:0]  seg;
    logic [2:0]  which_l;
    logic [7:0]  seg_l;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] w;
        logic [7:0] s;
        logic [7:0] sl;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hex_scan_display #(.DIV(DIV), .LZB(1'b0)) dut (
        .clk   (clk),
        .Rst   (Rst),
        .data  (data),
        .which (which),
        .seg   (seg)
    );

    hex_scan_display #(.DIV(DIV), .LZB(1'b1)) dut_lzb (
        .clk   (clk),
        .Rst   (Rst),
        .data  (data),
        .which (which_l),
        .seg   (seg_l)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_font(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] ref_seg(input logic [32:0] d, input int i, input bit lzb);
        logic [31:0] v;
        logic [31:0] up;
        v  = d[32:1];
        up = v >> (4 * i);
        if (!d[0]) return 8'hBF;
        if (lzb && (i != 0) && (up == 32'd0)) return 8'hFF;
        return ref_font(up[3:0]);
    endfunction

    // Queue the expected output of digits lo..hi for a shadow value d.
    task automatic push_frame(input logic [32:0] d, input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.w  = 3'(i);
            e.s  = ref_seg(d, i, 1'b0);
            e.sl = ref_seg(d, i, 1'b1);
            exp_q.push_back(e);
        end
    endtask

    // ---------------- output monitor / scoreboard consumer ----------------
    task automatic monitor();
        int         since  = 0;
        logic [2:0] prev_w = 3'd0;
        exp_t       e;
        forever begin
            @(posedge clk);
            #1;
            if (Rst) begin
                since  = 0;
                prev_w = which;
            end else begin
                since++;
                if (which !== prev_w) begin
                    checks++;
                    if (since != DIV) begin
                        failures++;
                        $display("FAIL tick_spacing: got %0d cycles, expected %0d", since, DIV);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tick: which=%0d with nothing expected", which);
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (which !== e.w || which_l !== e.w) begin
                            failures++;
                            $display("FAIL which: got %0d/%0d expected %0d", which, which_l, e.w);
                        end
                        checks++;
                        if (seg !== e.s) begin
                            failures++;
                            $display("FAIL seg digit %0d: got %h expected %h", e.w, seg, e.s);
                        end
                        checks++;
                        if (seg_l !== e.sl) begin
                            failures++;
                            $display("FAIL seg_lzb digit %0d: got %h expected %h", e.w, seg_l, e.sl);
                        end
                        $display("tick which=%0d seg=%h seg_lzb=%h shadow_src=%h", which, seg, seg_l, data);
                    end
                    since  = 0;
                    prev_w = which;
                end
            end
        end
    endtask

    // Bounded wait until every queued expectation has been consumed.
    task automatic wait_drain(input int max_cyc, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d expected ticks still pending after %0d cycles",
                     name, exp_q.size(), max_cyc);
            exp_q.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst  = 1'b1;
        data = 33'h0_2468ACE1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (which !== 3'd0 || which_l !== 3'd0) begin
            failures++;
            $display("FAIL reset_which: got %0d/%0d expected 0", which, which_l);
        end
        checks++;
        if (seg !== 8'hFF) begin
            failures++;
            $display("FAIL reset_seg: got %h expected ff", seg);
        end
        checks++;
        if (seg_l !== 8'hFF) begin
            failures++;
            $display("FAIL reset_seg_lzb: got %h expected ff", seg_l);
        end
    endtask

    // Digits 1..7 show dashes from the empty shadow, then the wrap captures data.
    task automatic test_first_frame();
        push_frame(33'h0, 1, 7);
        push_frame(data, 0, 7);
        @(posedge clk);
        #3;
        Rst = 1'b0;
        wait_drain(200, "first_frame");
    endtask

    // Data changing mid-frame must not reach the display until the next frame.
    task automatic test_hold_midframe();
        data = 33'h0_00000003;
        push_frame(data, 0, 3);
        wait_drain(100, "hold_a");
        data = 33'h0_00000005;
        push_frame(33'h0_00000003, 4, 7);
        push_frame(data, 0, 7);
        wait_drain(100, "hold_b");
    endtask

    task automatic test_invalid();
        data = 33'h1_FFFFFFFE;
        push_frame(data, 0, 7);
        wait_drain(100, "invalid");
    endtask

    task automatic test_lzb();
        data = 33'h0_00001A01;
        push_frame(data, 0, 7);
        wait_drain(100, "lzb_d00");
        data = 33'h0_00000001;
        push_frame(data, 0, 7);
        wait_drain(100, "lzb_zero");
    endtask

    // Eight consecutive frames (64 ticks) of random values, valid flags and
    // leading-zero counts, new data offered each frame.
    task automatic test_back_to_back();
        logic [31:0] v;
        for (int f = 0; f < 8; f++) begin
            v    = $urandom >> $urandom_range(0, 31);
            data = {v, ($urandom_range(0, 3) != 0)};
            push_frame(data, 0, 7);
            wait_drain(100, "back_to_back");
        end
    endtask

    // Reset asserted with which=5 and the prescaler at 2; the restart must
    // match power-up exactly.
    task automatic test_reset_mid();
        data = 33'h0_0000F0E1;
        push_frame(data, 0, 5);
        wait_drain(100, "pre_reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        Rst  = 1'b1;
        data = 33'h0_2468ACE1;
        #1;
        checks++;
        if (which !== 3'd0 || which_l !== 3'd0) begin
            failures++;
            $display("FAIL midreset_which: got %0d/%0d expected 0", which, which_l);
        end
        checks++;
        if (seg !== 8'hFF || seg_l !== 8'hFF) begin
            failures++;
            $display("FAIL midreset_seg: got %h/%h expected ff", seg, seg_l);
        end
        exp_q.delete();
        push_frame(33'h0, 1, 7);
        push_frame(data, 0, 7);
        @(posedge clk);
        #3;
        Rst = 1'b0;
        wait_drain(200, "post_reset");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_first_frame();
        test_hold_midframe();
        test_invalid();
        test_lzb();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
